keypad_debouncer: RTL and testbench
===================================

// Module: keypad_debouncer
// PURPOSE
//  Input front end for the dino game top level.
//  - Synchronises and debounces the raw keypad lines 0-9 and the '#' line.
//  - Outputs clean levels, one-cycle press/release pulses, an encoded code of
//    the most recent press, and a multi-key flag.
//  - Its KEY_LEVEL / KEY_PRESS outputs feed the game FSM and edge triggers in
//    place of the raw KEY / KEY_HASH pins.
// PARAMETERS
//  NKEYS          11       number of key lines; bit 10 = '#', bits 9..0 = digits
//  CLK_HZ         1000000  CLK frequency in Hz
//  SAMPLE_US      1000     debounce sample period in us
//  STABLE_SAMPLES 8        consecutive differing samples needed to accept a change (>=2)
//  DIV = CLK_HZ/1000000*SAMPLE_US is derived, not overridable (default 1000 cycles)
// PORTS
//  CLK          in   1      system clock, 1 MHz
//  rst          in   1      asynchronous, active-high reset
//  KEY_RAW      in   NKEYS  raw, asynchronous, bouncing key lines, 1 = pressed
//  KEY_LEVEL    out  NKEYS  debounced key levels
//  KEY_PRESS    out  NKEYS  1-cycle pulse per key on a debounced 0->1
//  KEY_RELEASE  out  NKEYS  1-cycle pulse per key on a debounced 1->0
//  ANY_LEVEL    out  1      OR of KEY_LEVEL (combinational from KEY_LEVEL regs)
//  KEY_CODE     out  4      index of the most recently pressed key; 4'hF = none since reset
//  CODE_VALID   out  1      1-cycle pulse when KEY_CODE is updated
//  MULTI        out  1      registered: popcount(KEY_LEVEL) > 1
// BEHAVIOUR
//  Reset (async, any time, including mid-debounce)
//  - KEY_LEVEL, KEY_PRESS, KEY_RELEASE, CODE_VALID, MULTI = 0; KEY_CODE = 4'hF.
//  - Synchroniser FFs, tick counter and all per-key counters are cleared.
//  - A key held through reset release is treated as a new press after the
//    normal latency.
//  Synchroniser
//  - Two FFs per line; the debouncer sees only the second stage, s[i].
//  Tick
//  - Free-running counter 0..DIV-1, independent of the inputs.
//  - tick = 1 for one cycle when the count is DIV-1, then it wraps to 0.
//  Per-key debounce (independent counter cnt[i], width clog2(STABLE_SAMPLES))
//  - Evaluated on tick only; no change between ticks.
//  - On tick, if s[i] == KEY_LEVEL[i]: cnt[i] <= 0.
//  - On tick, if s[i] != KEY_LEVEL[i] and cnt[i] < STABLE_SAMPLES-1: cnt[i]++.
//  - On tick, if s[i] != KEY_LEVEL[i] and cnt[i] == STABLE_SAMPLES-1:
//    KEY_LEVEL[i] <= s[i] and cnt[i] <= 0.
//  - Pulses shorter than STABLE_SAMPLES consecutive ticks are rejected.
//  - Accept latency from a raw edge: 2 sync cycles, then STABLE_SAMPLES ticks,
//    i.e. 2+(STABLE_SAMPLES-1)*DIV+1 .. 2+STABLE_SAMPLES*DIV cycles.
//  Pulses
//  - KEY_PRESS[i] / KEY_RELEASE[i] are registered on the same edge that
//    updates KEY_LEVEL[i], high for exactly 1 cycle.
//  - Several keys may pulse in the same cycle.
//  Code
//  - The cycle after any KEY_PRESS bit is high, KEY_CODE <= lowest set index
//    of the KEY_PRESS vector, and CODE_VALID = 1 for 1 cycle.
//  - Releases never change KEY_CODE.
//  - KEY_CODE holds its value until the next press.
//  MULTI
//  - Updated every cycle from KEY_LEVEL, 1 cycle after the level changes.
//  Simultaneous events
//  - A press on key a and a release on key b in the same tick are both
//    reported in the same cycle.
// TESTING (bench overrides: SAMPLE_US=10 -> DIV=10, STABLE_SAMPLES=4)
//  1. Reset with KEY_RAW=0 -> all outputs 0, KEY_CODE=4'hF; tick pulses every 10 cycles.
//  2. KEY_RAW[3] clean 0->1 held 100 cycles -> KEY_LEVEL[3] rises 33..42 cycles
//     after the edge; KEY_PRESS[3] 1 cycle; next cycle KEY_CODE=3, CODE_VALID 1 cycle.
//  3. Bounce: KEY_RAW[5] high 25 cycles, low 5, high 60 -> exactly one KEY_PRESS[5];
//     a lone 25-cycle high glitch -> no KEY_PRESS, cnt back to 0.
//  4. Keys 7 and 10 rise on the same cycle and are held -> both PRESS bits pulse in one
//     cycle; KEY_CODE=7; MULTI=1 one cycle after the levels rise.
//  5. Release key 10 while key 2 is pressed in the same window -> KEY_RELEASE[10] and
//     KEY_PRESS[2] in the same cycle; KEY_CODE=2; MULTI stays 1.
//  6. Assert rst mid-debounce with key 4 held -> outputs clear at once; after release,
//     KEY_PRESS[4] within 42 cycles; KEY_CODE=4.

Source files
------------

// File: rtl/keypad_debouncer.sv
// Keypad front end: two-FF synchroniser, shared sample tick and per-key
// saturating debounce counters, plus press/release pulses, last-press code and multi-key flag.
module keypad_debouncer #(
   parameter int NKEYS          = 11,
   parameter int CLK_HZ         = 1000000,
   parameter int SAMPLE_US      = 1000,
   parameter int STABLE_SAMPLES = 8
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic [NKEYS-1:0] KEY_RAW,
   output logic [NKEYS-1:0] KEY_LEVEL,
   output logic [NKEYS-1:0] KEY_PRESS,
   output logic [NKEYS-1:0] KEY_RELEASE,
   output logic             ANY_LEVEL,
   output logic [3:0]       KEY_CODE,
   output logic             CODE_VALID,
   output logic             MULTI
);

   localparam int DIV = CLK_HZ / 1000000 * SAMPLE_US;
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW  = $clog2(STABLE_SAMPLES);
   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_SAMPLES - 1);

   logic [NKEYS-1:0] sync_a;
   logic [NKEYS-1:0] sync_s;
   logic [TW-1:0]    tick_cnt;
   logic             tick;
   logic [CW-1:0]    cnt [NKEYS];
   logic [3:0]       press_idx;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         sync_a <= '0;
         sync_s <= '0;
      end else begin
         sync_a <= KEY_RAW;
         sync_s <= sync_a;
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // NOTE: the per-key counters are individual flops, not a RAM, so they are
   // cleared by reset like any other state.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         KEY_LEVEL   <= '0;
         KEY_PRESS   <= '0;
         KEY_RELEASE <= '0;
         for (int i = 0; i < NKEYS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         KEY_PRESS   <= '0;
         KEY_RELEASE <= '0;
         if (tick) begin
            for (int i = 0; i < NKEYS; i++) begin
               if (sync_s[i] == KEY_LEVEL[i]) begin
                  cnt[i] <= '0;
               end else if (cnt[i] == CNT_LAST) begin
                  KEY_LEVEL[i]   <= sync_s[i];
                  KEY_PRESS[i]   <= sync_s[i];
                  KEY_RELEASE[i] <= ~sync_s[i];
                  cnt[i]         <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end
         end
      end
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      press_idx = 4'hF;
      for (int i = NKEYS - 1; i >= 0; i--) begin
         if (KEY_PRESS[i]) begin
            press_idx = 4'(i);
         end
      end
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         KEY_CODE   <= 4'hF;
         CODE_VALID <= 1'b0;
         MULTI      <= 1'b0;
      end else begin
         CODE_VALID <= |KEY_PRESS;
         if (|KEY_PRESS) begin
            KEY_CODE <= press_idx;
         end
         MULTI <= ($countones(KEY_LEVEL) > 1);
      end
   end

   assign ANY_LEVEL = |KEY_LEVEL;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench for keypad_debouncer with a sliding-window reference model
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_keypad_debouncer;

   localparam int NK     = 11;
   localparam int DIV    = 10;
   localparam int STABLE = 4;

   logic          CLK = 1'b0;
   logic          rst;
   logic [NK-1:0] KEY_RAW;
   logic [NK-1:0] KEY_LEVEL, KEY_PRESS, KEY_RELEASE;
   logic          ANY_LEVEL, CODE_VALID, MULTI;
   logic [3:0]    KEY_CODE;

   int passes = 0;
   int total  = 0;
   int press5 = 0;

   keypad_debouncer #(
      .NKEYS(NK), .CLK_HZ(1000000), .SAMPLE_US(10), .STABLE_SAMPLES(STABLE)
   ) dut (
      .CLK(CLK), .rst(rst), .KEY_RAW(KEY_RAW),
      .KEY_LEVEL(KEY_LEVEL), .KEY_PRESS(KEY_PRESS), .KEY_RELEASE(KEY_RELEASE),
      .ANY_LEVEL(ANY_LEVEL), .KEY_CODE(KEY_CODE), .CODE_VALID(CODE_VALID),
      .MULTI(MULTI)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: raw input delayed two edges, tick on every DIV-th edge
   // since reset, and a key level flips once its last STABLE tick samples all differ.
   logic [NK-1:0] sync_q[$];
   logic [NK-1:0] tick_hist[$];
   int            n_edges = 0;
   logic [NK-1:0] m_level = '0, m_press = '0, m_release = '0;
   logic [3:0]    m_code = 4'hF;
   logic          m_valid = 1'b0, m_multi = 1'b0;

   function automatic logic [3:0] lowest(input logic [NK-1:0] v);
      for (int i = 0; i < NK; i++) if (v[i]) return 4'(i);
      return 4'hF;
   endfunction

   task automatic model_step();
      logic [NK-1:0] s, prev_level, prev_press;
      bit all_diff;
      if (rst) begin
         sync_q.delete();
         sync_q.push_back('0);
         sync_q.push_back('0);
         tick_hist.delete();
         n_edges   = 0;
         m_level   = '0;
         m_press   = '0;
         m_release = '0;
         m_code    = 4'hF;
         m_valid   = 1'b0;
         m_multi   = 1'b0;
      end else begin
         s = sync_q.pop_front();
         sync_q.push_back(KEY_RAW);
         n_edges++;
         prev_level = m_level;
         prev_press = m_press;
         m_press    = '0;
         m_release  = '0;
         if (n_edges % DIV == 0) begin
            tick_hist.push_back(s);
            if (tick_hist.size() > STABLE) void'(tick_hist.pop_front());
            if (tick_hist.size() == STABLE) begin
               for (int k = 0; k < NK; k++) begin
                  all_diff = 1'b1;
                  foreach (tick_hist[j]) if (tick_hist[j][k] == prev_level[k]) all_diff = 1'b0;
                  if (all_diff) begin
                     m_level[k]   = ~prev_level[k];
                     m_press[k]   = ~prev_level[k];
                     m_release[k] = prev_level[k];
                  end
               end
            end
         end
         m_valid = (prev_press != '0);
         if (m_valid) m_code = lowest(prev_press);
         m_multi = ($countones(prev_level) > 1);
      end
   endtask

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         model_step();
         check("level",   32'(KEY_LEVEL),   32'(m_level));
         check("press",   32'(KEY_PRESS),   32'(m_press));
         check("release", 32'(KEY_RELEASE), 32'(m_release));
         check("any",     32'(ANY_LEVEL),   32'(|m_level));
         check("code",    32'(KEY_CODE),    32'(m_code));
         check("valid",   32'(CODE_VALID),  32'(m_valid));
         check("multi",   32'(MULTI),       32'(m_multi));
         if (KEY_PRESS[5]) press5++;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Returns the number of edges until the chosen pulse appears, 0 on timeout.
   task automatic wait_evt(input int key, input bit rel, input int limit, output int k);
      k = 0;
      for (int c = 1; c <= limit; c++) begin
         @(posedge CLK);
         #1;
         if (rel ? KEY_RELEASE[key] : KEY_PRESS[key]) begin
            k = c;
            break;
         end
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int k;
      int p0;
      rst     = 1'b1;
      KEY_RAW = '0;
      cycles(3);
      check("reset level", 32'(KEY_LEVEL), 32'h0);
      check("reset code",  32'(KEY_CODE),  32'hF);
      check("reset multi", 32'(MULTI),     32'h0);
      rst = 1'b0;
      cycles(30);
      check("idle level", 32'(KEY_LEVEL), 32'h0);
      check("idle code",  32'(KEY_CODE),  32'hF);

      // Clean press on key 3
      KEY_RAW[3] = 1'b1;
      wait_evt(3, 1'b0, 60, k);
      check("key3 latency in 33..42", 32'(k >= 33 && k <= 42), 32'h1);
      check("key3 press vector", 32'(KEY_PRESS), 32'h008);
      check("key3 level",        32'(KEY_LEVEL), 32'h008);
      next_cycle();
      check("key3 code",  32'(KEY_CODE),   32'h3);
      check("key3 valid", 32'(CODE_VALID), 32'h1);
      next_cycle();
      check("key3 valid drop", 32'(CODE_VALID), 32'h0);
      @(negedge CLK);
      KEY_RAW[3] = 1'b0;
      cycles(60);

      // Bounce on key 5 yields exactly one press
      p0 = press5;
      KEY_RAW[5] = 1'b1;
      cycles(25);
      KEY_RAW[5] = 1'b0;
      cycles(5);
      KEY_RAW[5] = 1'b1;
      cycles(60);
      check("bounce single press", 32'(press5 - p0), 32'h1);
      check("bounce level",        32'(KEY_LEVEL[5]), 32'h1);
      KEY_RAW[5] = 1'b0;
      cycles(60);

      // Two short glitches separated by a quiet gap never press
      p0 = press5;
      KEY_RAW[5] = 1'b1;
      cycles(25);
      KEY_RAW[5] = 1'b0;
      cycles(60);
      KEY_RAW[5] = 1'b1;
      cycles(25);
      KEY_RAW[5] = 1'b0;
      cycles(60);
      check("glitch no press", 32'(press5 - p0), 32'h0);
      check("glitch level",    32'(KEY_LEVEL[5]), 32'h0);

      // Keys 7 and 10 together
      KEY_RAW = 11'h480;
      wait_evt(7, 1'b0, 60, k);
      check("dual latency in 33..42", 32'(k >= 33 && k <= 42), 32'h1);
      check("dual press vector", 32'(KEY_PRESS), 32'h480);
      check("dual multi lag",    32'(MULTI),     32'h0);
      next_cycle();
      check("dual code",  32'(KEY_CODE),   32'h7);
      check("dual valid", 32'(CODE_VALID), 32'h1);
      check("dual multi", 32'(MULTI),      32'h1);
      @(negedge CLK);
      cycles(20);

      // Release 10 and press 2 in the same window
      KEY_RAW = 11'h084;
      wait_evt(10, 1'b1, 60, k);
      check("swap found",         32'(k > 0),       32'h1);
      check("swap release vector", 32'(KEY_RELEASE), 32'h400);
      check("swap press vector",   32'(KEY_PRESS),   32'h004);
      check("swap multi",          32'(MULTI),       32'h1);
      next_cycle();
      check("swap code",  32'(KEY_CODE), 32'h2);
      check("swap multi hold", 32'(MULTI), 32'h1);
      @(negedge CLK);
      KEY_RAW = 11'h080;
      cycles(60);

      // Reset mid-debounce with key 4 held and key 7 still down
      KEY_RAW = 11'h090;
      cycles(20);
      rst = 1'b1;
      #1;
      check("midrst level", 32'(KEY_LEVEL), 32'h0);
      check("midrst code",  32'(KEY_CODE),  32'hF);
      check("midrst multi", 32'(MULTI),     32'h0);
      check("midrst any",   32'(ANY_LEVEL), 32'h0);
      cycles(3);
      rst = 1'b0;
      wait_evt(4, 1'b0, 60, k);
      check("key4 latency after reset", 32'(k), 32'd40);
      check("key4 press vector", 32'(KEY_PRESS), 32'h090);
      next_cycle();
      check("key4 code",  32'(KEY_CODE),   32'h4);
      check("key4 valid", 32'(CODE_VALID), 32'h1);
      check("key4 multi", 32'(MULTI),      32'h1);
      @(negedge CLK);
      KEY_RAW = '0;
      cycles(60);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", passes, total);
      $fatal(1);
   end

endmodule
